// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, keeps at most one imem request in flight,
// and feeds the IF/ID register through a one-entry skid buffer for ID stalls.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc_out,
  output logic [31:0] inst_out,
  output logic        inst_valid
);

  typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;

  state_t      state;
  logic [31:0] req_pc;
  logic [31:0] target_pc;
  logic [31:0] skid_pc;
  logic [31:0] skid_inst;
  logic        discard;
  logic        out_free;

  // Request is gated by rst_n so it drops immediately on reset and rises right after release.
  assign imem_req  = rst_n && (state == FETCH);
  assign imem_addr = req_pc;
  assign out_free  = !stall || !inst_valid;

  // PC, skid and IF/ID output registers; a redirect overrides every other transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH;
      req_pc     <= RESET_PC;
      target_pc  <= RESET_PC;
      discard    <= 1'b0;
      skid_pc    <= 32'h0000_0000;
      skid_inst  <= 32'h0000_0000;
      pc_out     <= 32'h0000_0000;
      inst_out   <= 32'h0000_0000;
      inst_valid <= 1'b0;
    end else if (redirect) begin
      state      <= FETCH;
      inst_valid <= 1'b0;
      // An unanswered request pins imem_addr; park the target until that ack is dropped.
      if (state == FETCH && !imem_ack) begin
        target_pc <= redirect_pc;
        discard   <= 1'b1;
      end else begin
        req_pc    <= redirect_pc;
        discard   <= 1'b0;
      end
    end else begin
      case (state)
        FETCH: begin
          if (imem_ack && discard) begin
            req_pc  <= target_pc;
            discard <= 1'b0;
            if (!stall) begin
              inst_valid <= 1'b0;
            end
          end else if (imem_ack) begin
            req_pc <= req_pc + PC_STEP;
            if (out_free) begin
              pc_out     <= req_pc;
              inst_out   <= imem_rdata;
              inst_valid <= 1'b1;
            end else begin
              skid_pc   <= req_pc;
              skid_inst <= imem_rdata;
              state     <= HOLD;
            end
          end else if (!stall) begin
            inst_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            pc_out     <= skid_pc;
            inst_out   <= skid_inst;
            inst_valid <= 1'b1;
            state      <= FETCH;
          end
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

endmodule
